// File: rtl/ttt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ttt_pkg
//  Purpose  : Shared constants, FSM state encoding and cursor helpers for the
//             tic-tac-toe position encoder.
//  Revision : 1.0 - initial release
// ============================================================================
package ttt_pkg;

  localparam int         NUM_CELLS  = 9;
  localparam logic [3:0] POS_NONE   = 4'd0;
  localparam logic [3:0] POS_MIN    = 4'd1;
  localparam logic [3:0] POS_MAX    = 4'd9;
  // Nine steps is one full revolution of the board.
  localparam logic [3:0] STEP_LIMIT = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SRCH_FWD = 3'd1,
    ST_SRCH_BWD = 3'd2,
    ST_COMMIT   = 3'd3,
    ST_FULL     = 3'd4
  } ttt_state_e;

  // Next cell going forward, wrapping 9 -> 1.
  function automatic logic [3:0] pos_fwd(input logic [3:0] p);
    return (p >= POS_MAX) ? POS_MIN : p + 4'd1;
  endfunction

  // Next cell going backward, wrapping 1 -> 9.
  function automatic logic [3:0] pos_bwd(input logic [3:0] p);
    return (p <= POS_MIN) ? POS_MAX : p - 4'd1;
  endfunction

  // One-hot cell mask for a cursor code; code 0 yields an all-zero mask.
  function automatic logic [NUM_CELLS-1:0] pos_onehot(input logic [3:0] p);
    logic [NUM_CELLS-1:0] oh;
    for (int i = 0; i < NUM_CELLS; i++) begin
      oh[i] = (p == 4'(i + 1));
    end
    return oh;
  endfunction

endpackage : ttt_pkg
`default_nettype wire

// File: rtl/ttt_pos_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : ttt_pos_encoder_if
//  Purpose  : Button / board-state inputs and cursor / commit outputs of the
//             position encoder. The master side drives buttons and board
//             occupancy; the slave side (the encoder) drives the cursor.
//  Revision : 1.0 - initial release
// ============================================================================
interface ttt_pos_encoder_if;
  import ttt_pkg::*;

  logic                 btn_next;
  logic                 btn_prev;
  logic                 btn_sel;
  logic                 enable;
  logic [NUM_CELLS-1:0] occupied;
  logic [3:0]           pos_sw;
  logic [NUM_CELLS-1:0] cursor;
  logic                 pos_valid;
  logic                 full;

  modport master (
    output btn_next, btn_prev, btn_sel, enable, occupied,
    input  pos_sw, cursor, pos_valid, full
  );

  modport slave (
    input  btn_next, btn_prev, btn_sel, enable, occupied,
    output pos_sw, cursor, pos_valid, full
  );

endinterface : ttt_pos_encoder_if
`default_nettype wire

// File: rtl/ttt_edge_det.sv
`default_nettype none
// ============================================================================
//  Module   : ttt_edge_det
//  Purpose  : Rising-edge detector for a debounced level. The pulse is high
//             for the single cycle in which the level is high and the
//             registered previous level is low.
//  Revision : 1.0 - initial release
// ============================================================================
module ttt_edge_det (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_level,
  output logic      o_rise
);

  logic r_prev;

  // Remember last cycle's level so a held input produces a single edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule : ttt_edge_det
`default_nettype wire

// File: rtl/ttt_pos_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : ttt_pos_encoder
//  Purpose  : Button-driven cursor over a 3x3 board. NEXT/PREV walk to the
//             next free cell, SEL commits the cursor cell with a one-cycle
//             strobe, and an occupied cursor cell triggers an automatic
//             forward search. A board with no free cell parks in FULL.
//  Revision : 1.0 - initial release
// ============================================================================
module ttt_pos_encoder
  import ttt_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst,
  ttt_pos_encoder_if.slave   bus
);

  logic w_rise_sel;
  logic w_rise_next;
  logic w_rise_prev;

  ttt_edge_det u_edge_sel (
    .clk     (clk),
    .rst     (rst),
    .i_level (bus.btn_sel),
    .o_rise  (w_rise_sel)
  );

  ttt_edge_det u_edge_next (
    .clk     (clk),
    .rst     (rst),
    .i_level (bus.btn_next),
    .o_rise  (w_rise_next)
  );

  ttt_edge_det u_edge_prev (
    .clk     (clk),
    .rst     (rst),
    .i_level (bus.btn_prev),
    .o_rise  (w_rise_prev)
  );

  ttt_state_e           r_state;
  ttt_state_e           w_state_nxt;
  logic [3:0]           r_pos;
  logic [3:0]           w_pos_nxt;
  logic [3:0]           r_steps;
  logic [3:0]           w_steps_nxt;
  logic [NUM_CELLS-1:0] r_cursor;
  logic                 r_pos_valid;
  logic                 r_full;

  // Buttons only count while enabled; a disabled press is simply not an edge.
  logic w_sel;
  logic w_next;
  logic w_prev;
  assign w_sel  = bus.enable & w_rise_sel;
  assign w_next = bus.enable & w_rise_next;
  assign w_prev = bus.enable & w_rise_prev;

  // Occupancy of the current cell and of the cell one search step away.
  logic [3:0] w_step_pos;
  logic       w_cur_occ;
  logic       w_step_occ;
  assign w_step_pos = (r_state == ST_SRCH_BWD) ? pos_bwd(r_pos) : pos_fwd(r_pos);
  assign w_cur_occ  = |(pos_onehot(r_pos) & bus.occupied);
  assign w_step_occ = |(pos_onehot(w_step_pos) & bus.occupied);

  // State, cursor and step counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pos   <= POS_MIN;
      r_steps <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_steps <= w_steps_nxt;
    end
  end

  // Next-state logic: SEL beats NEXT beats PREV, then the auto-search.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_steps_nxt = r_steps;
    unique case (r_state)
      ST_IDLE: begin
        if (w_sel) begin
          // A press on an occupied cell is swallowed; auto-search follows.
          if (!w_cur_occ) begin
            w_state_nxt = ST_COMMIT;
          end
        end else if (w_next) begin
          w_state_nxt = ST_SRCH_FWD;
          w_steps_nxt = 4'd0;
        end else if (w_prev) begin
          w_state_nxt = ST_SRCH_BWD;
          w_steps_nxt = 4'd0;
        end else if (w_cur_occ) begin
          w_state_nxt = ST_SRCH_FWD;
          w_steps_nxt = 4'd0;
        end
      end
      ST_SRCH_FWD, ST_SRCH_BWD: begin
        w_pos_nxt   = w_step_pos;
        w_steps_nxt = r_steps + 4'd1;
        // The ninth step returns to the origin, so the revolution is over
        // before that cell is reconsidered.
        if (r_steps + 4'd1 == STEP_LIMIT) begin
          w_state_nxt = ST_FULL;
          w_pos_nxt   = POS_NONE;
        end else if (!w_step_occ) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
      end
      ST_FULL: begin
        if (bus.occupied != '1) begin
          w_state_nxt = ST_IDLE;
          w_pos_nxt   = POS_MIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pos_nxt   = POS_MIN;
      end
    endcase
  end

  // Registered outputs; the one-hot cursor is derived from the same next
  // position as POS_SW so the two never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cursor    <= pos_onehot(POS_MIN);
      r_full      <= 1'b0;
      r_pos_valid <= 1'b0;
    end else begin
      r_cursor    <= pos_onehot(w_pos_nxt);
      r_full      <= (w_state_nxt == ST_FULL);
      r_pos_valid <= (r_state == ST_COMMIT) & bus.enable;
    end
  end

  assign bus.pos_sw    = r_pos;
  assign bus.cursor    = r_cursor;
  assign bus.pos_valid = r_pos_valid;
  assign bus.full      = r_full;

endmodule : ttt_pos_encoder
`default_nettype wire

// File: tb/tb_ttt_pos_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ttt_pos_encoder
//  Purpose  : Self-checking bench for ttt_pos_encoder: a cycle-level board
//             model compared every cycle, plus directed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ttt_pos_encoder;

  logic clk;
  logic rst;

  ttt_pos_encoder_if bus_if ();

  ttt_pos_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 searching forward, 2 searching backward, 3 commit, 4 full
  int m_mode  = 0;
  int m_pos   = 1;
  int m_steps = 0;
  bit m_pv    = 0;
  bit p_sel   = 0;
  bit p_next  = 0;
  bit p_prev  = 0;

  function automatic bit occ_at(input int p);
    return bus_if.occupied[p-1];
  endfunction

  always @(posedge clk) begin : model
    bit es, en, ep;
    es = bus_if.btn_sel  && !p_sel;
    en = bus_if.btn_next && !p_next;
    ep = bus_if.btn_prev && !p_prev;
    if (rst) begin
      m_mode = 0; m_pos = 1; m_steps = 0; m_pv = 0;
      p_sel = 0; p_next = 0; p_prev = 0;
    end else begin
      p_sel = bus_if.btn_sel; p_next = bus_if.btn_next; p_prev = bus_if.btn_prev;
      m_pv = (m_mode == 3) && bus_if.enable;
      if (!bus_if.enable) begin
        es = 0; en = 0; ep = 0;
      end
      case (m_mode)
        0: begin
          if (es) begin
            if (!occ_at(m_pos)) m_mode = 3;
          end else if (en) begin
            m_mode = 1; m_steps = 0;
          end else if (ep) begin
            m_mode = 2; m_steps = 0;
          end else if (occ_at(m_pos)) begin
            m_mode = 1; m_steps = 0;
          end
        end
        1, 2: begin
          m_pos   = (m_mode == 1) ? (m_pos % 9) + 1 : ((m_pos + 7) % 9) + 1;
          m_steps = m_steps + 1;
          if (m_steps == 9) m_mode = 4;
          else if (!occ_at(m_pos)) m_mode = 0;
        end
        3: m_mode = 0;
        default: begin
          if (bus_if.occupied != 9'h1FF) begin
            m_mode = 0; m_pos = 1;
          end
        end
      endcase
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pos_sw",    32'(bus_if.pos_sw),    (m_mode == 4) ? 0 : m_pos);
      check("model_cursor",    32'(bus_if.cursor),    (m_mode == 4) ? 0 : (32'd1 << (m_pos - 1)));
      check("model_full",      32'(bus_if.full),      32'(m_mode == 4));
      check("model_pos_valid", 32'(bus_if.pos_valid), 32'(m_pv));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_out(input string name, input int pos, input int cur, input int full, input int pv);
    check({name, "_pos"},  32'(bus_if.pos_sw),    pos);
    check({name, "_cur"},  32'(bus_if.cursor),    cur);
    check({name, "_full"}, 32'(bus_if.full),      full);
    check({name, "_pv"},   32'(bus_if.pos_valid), pv);
  endtask

  initial begin
    int n_pv;
    rst = 1'b1;
    bus_if.btn_next = 0; bus_if.btn_prev = 0; bus_if.btn_sel = 0;
    bus_if.enable = 1; bus_if.occupied = 9'h000;
    tick(2);
    chk_en = 1'b1;
    check_out("reset", 1, 9'h001, 0, 0);
    rst = 1'b0;
    tick(1);

    // Single SEL press on a free board: strobe two cycles after the press.
    bus_if.btn_sel = 1; tick(1);
    bus_if.btn_sel = 0; tick(1);
    check_out("sel_commit", 1, 9'h001, 0, 1);
    tick(1);
    check_out("sel_after", 1, 9'h001, 0, 0);

    // PREV from 1 wraps to 9; then NEXT from 9 skips occupied 1, lands on 2.
    bus_if.btn_prev = 1; tick(1);
    bus_if.btn_prev = 0; tick(1);
    check("prev_wrap_pos", 32'(bus_if.pos_sw), 9);
    bus_if.occupied = 9'h001;
    bus_if.btn_next = 1; tick(1);
    bus_if.btn_next = 0; tick(2);
    check_out("next_wrap", 2, 9'h002, 0, 0);

    // SEL and NEXT together: commit only, cursor stays on 2.
    bus_if.btn_sel = 1; bus_if.btn_next = 1; tick(1);
    bus_if.btn_sel = 0; bus_if.btn_next = 0; tick(1);
    check_out("sel_next", 2, 9'h002, 0, 1);
    // Mark the committed cell taken: auto-search forward to 3.
    bus_if.occupied = 9'h003; tick(2);
    check_out("auto_after_commit", 3, 9'h004, 0, 0);

    // Backward search from 1 over 9..2 all occupied: abort to FULL.
    rst = 1; tick(1); rst = 0;
    bus_if.occupied = 9'h1FE;
    bus_if.btn_prev = 1; tick(1);
    bus_if.btn_prev = 0; tick(8);
    check("bwd_step8_pos", 32'(bus_if.pos_sw), 2);
    tick(1);
    check_out("bwd_full", 0, 0, 1, 0);
    bus_if.occupied = 9'h1EE; tick(1);
    check_out("full_exit", 1, 9'h001, 0, 0);

    // Truly full board parks in FULL; freeing cell 5 lets auto-search find it.
    bus_if.occupied = 9'h1FF; tick(13);
    check_out("board_full", 0, 0, 1, 0);
    bus_if.occupied = 9'h1EF; tick(10);
    check_out("refill_search", 5, 9'h010, 0, 0);

    // ENABLE low blocks commits; a long held SEL commits exactly once.
    bus_if.occupied = 9'h000;
    bus_if.enable = 0; bus_if.btn_sel = 1;
    n_pv = 0;
    tick(1); n_pv += int'(bus_if.pos_valid);
    bus_if.btn_sel = 0;
    for (int i = 0; i < 4; i++) begin tick(1); n_pv += int'(bus_if.pos_valid); end
    check("disabled_sel_pulses", 32'(n_pv), 0);
    bus_if.enable = 1; bus_if.btn_sel = 1;
    n_pv = 0;
    for (int i = 0; i < 20; i++) begin tick(1); n_pv += int'(bus_if.pos_valid); end
    bus_if.btn_sel = 0;
    for (int i = 0; i < 3; i++) begin tick(1); n_pv += int'(bus_if.pos_valid); end
    check("held_sel_pulses", 32'(n_pv), 1);

    // Reset in the middle of a forward search.
    bus_if.occupied = 9'h0EF;
    bus_if.btn_next = 1; tick(1);
    bus_if.btn_next = 0; tick(1);
    check("mid_search_pos", 32'(bus_if.pos_sw), 6);
    rst = 1; tick(1);
    check_out("rst_mid_search", 1, 9'h001, 0, 0);
    rst = 0; tick(8);
    check_out("post_reset_auto", 5, 9'h010, 0, 0);

    bus_if.occupied = 9'h000;
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ttt_pos_encoder
`default_nettype wire

// File: doc/ttt_pos_encoder.md
TTT_POS_ENCODER -- requirements
Module: ttt_pos_encoder

Interface
REQ-001 SHALL expose CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL expose RST, input, 1; reset is synchronous and active-high.
REQ-003 SHALL expose BTN_NEXT, input, 1: debounced level, move cursor forward.
REQ-004 SHALL expose BTN_PREV, input, 1: debounced level, move cursor backward.
REQ-005 SHALL expose BTN_SEL, input, 1: debounced level, commit cursor cell.
REQ-006 SHALL expose ENABLE, input, 1: 0 means buttons are ignored and commits are blocked.
REQ-007 SHALL expose OCCUPIED, input, 9: bit k high means cell k+1 is taken.
REQ-008 SHALL expose POS_SW, output, 4: cursor code 1..9; 0 when the board is full.
REQ-009 SHALL expose CURSOR, output, 9: one-hot of the cursor (bit POS_SW-1); all-zero when full.
REQ-010 SHALL expose POS_VALID, output, 1: one-cycle commit strobe, qualifying POS_SW.
REQ-011 SHALL expose FULL, output, 1: no free cell exists.

Function
REQ-012 SHALL detect rising edges of each BTN_* (registered previous level); an input held high yields exactly one edge.
REQ-013 SHALL run FSM states IDLE, SRCH_FWD, SRCH_BWD, COMMIT, FULL_ST.
REQ-014 In IDLE, edge priority SHALL be SEL > NEXT > PREV; a lower-priority edge in the same cycle is discarded.
REQ-015 IDLE with a SEL edge, ENABLE=1 and the cursor cell free SHALL go to COMMIT; if the cursor cell is occupied, the SEL edge is ignored.
REQ-016 COMMIT SHALL assert POS_VALID for exactly one cycle with the current POS_SW, then return to IDLE.
REQ-017 IDLE with a NEXT edge (ENABLE=1) SHALL enter SRCH_FWD; a PREV edge SHALL enter SRCH_BWD.
REQ-018 Each search cycle SHALL step the cursor one position: forward 9->1, backward 1->9.
REQ-019 Search SHALL stop in IDLE on the first cell whose OCCUPIED bit is 0, sampled after that step.
REQ-020 A 4-bit step counter SHALL abort the search after 9 steps with no free cell and enter FULL_ST.
REQ-021 IDLE with the cursor cell occupied (set externally or after a commit) and no edge SHALL auto-enter SRCH_FWD; this auto-search ignores ENABLE.
REQ-022 FULL_ST SHALL hold FULL=1, POS_SW=0 and CURSOR=0.
REQ-023 FULL_ST SHALL leave, on any cycle where OCCUPIED != 9'h1FF, with the cursor set to cell 1 and the FSM in IDLE.
REQ-024 Button edges arriving during SRCH_*, COMMIT or FULL_ST SHALL be dropped, not queued.
REQ-025 ENABLE=0 SHALL force POS_VALID=0 and freeze the cursor, except for the auto-search in REQ-021.
REQ-026 All outputs SHALL be registered; POS_SW and CURSOR SHALL be mutually consistent every cycle.

Reset
REQ-027 RST=1 at a clock edge SHALL set: state IDLE, POS_SW=1, CURSOR=9'h001, POS_VALID=0, FULL=0, step counter 0, edge registers 0.
REQ-028 RST asserted mid-search or in COMMIT SHALL abort the operation with no POS_VALID pulse.
REQ-029 If cell 1 is occupied on reset release, REQ-021 applies in the first cycle after reset.

Structure
REQ-030 Shared package ttt_pkg SHALL hold the FSM state encoding, NUM_CELLS=9, POS_NONE=4'd0, POS_MIN=4'd1 and POS_MAX=4'd9.
REQ-031 One sub-module, ttt_edge_det (level in, one-cycle rise pulse out, synchronous reset), SHALL be instantiated once per button.

Verification
REQ-032 Reset, OCCUPIED=0, then a BTN_SEL pulse -> a single POS_VALID with POS_SW=1 two cycles after the press.
REQ-033 Cursor=9, OCCUPIED=9'h001, BTN_NEXT -> cursor wraps past 1 and lands on 2; POS_SW=2, CURSOR=9'h002.
REQ-034 Cursor=1, OCCUPIED=9'h1FE, BTN_PREV -> 9 steps, then FULL=1 and POS_SW=0; after clearing bit 4 -> IDLE, cursor=1.
REQ-035 SEL and NEXT rising in the same cycle with the cell free -> commit only, and the cursor is unchanged.
REQ-036 ENABLE=0 with a SEL press -> no POS_VALID; BTN_SEL held high for 20 cycles with ENABLE=1 -> exactly one POS_VALID.
REQ-037 RST asserted during SRCH_FWD -> next cycle POS_SW=1, POS_VALID=0, FULL=0, state IDLE.
